// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises word accesses from several requesters onto one
// single-port byte memory. Each access takes three cycles: IDLE -> ACCESS -> RESP.
module mem_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 2048
) (
  input  logic                        clock,
  input  logic                        nrst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        rsp_err,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        busy,
  output logic [ADDR_W-1:0]           mem_address,
  output logic                        mem_wr_en,
  output logic [DATA_W-1:0]           mem_data_in,
  input  logic [DATA_W-1:0]           mem_data_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_DEPTH - 2);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_next;
  logic [IDX_W-1:0]    rr, rr_next;
  logic [IDX_W-1:0]    idx, idx_next;
  logic                wr_q, wr_next;
  logic                legal_q, legal_next;
  logic [NUM_REQ-1:0]  ack_next;
  logic                rsp_err_next;
  logic [DATA_W-1:0]   rsp_rdata_next;
  logic                busy_next;
  logic [ADDR_W-1:0]   mem_address_next;
  logic                mem_wr_en_next;
  logic [DATA_W-1:0]   mem_data_in_next;

  logic                found;
  logic [IDX_W-1:0]    grant;
  logic [IDX_W:0]      cand;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_legal;

  // First pending request at or after the rr pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ))
        cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        grant = cand[IDX_W-1:0];
      end
    end
  end

  assign sel_addr  = req_addr[grant*ADDR_W +: ADDR_W];
  assign sel_legal = (sel_addr[0] == 1'b0) && (sel_addr <= LAST_WORD);

  always_comb begin
    state_next       = state;
    rr_next          = rr;
    idx_next         = idx;
    wr_next          = wr_q;
    legal_next       = legal_q;
    ack_next         = '0;
    rsp_err_next     = 1'b0;
    rsp_rdata_next   = rsp_rdata;
    busy_next        = 1'b0;
    mem_address_next = '0;
    mem_wr_en_next   = 1'b0;
    mem_data_in_next = '0;
    case (state)
      IDLE: begin
        if (found) begin
          idx_next         = grant;
          wr_next          = req_wr[grant];
          legal_next       = sel_legal;
          mem_address_next = sel_addr;
          mem_data_in_next = req_wdata[grant*DATA_W +: DATA_W];
          mem_wr_en_next   = req_wr[grant] & sel_legal;
          busy_next        = 1'b1;
          state_next       = ACCESS;
        end
      end
      ACCESS: begin
        // Memory read is combinational, so the addressed word is on mem_data_out now.
        ack_next[idx]  = 1'b1;
        rsp_err_next   = ~legal_q;
        rsp_rdata_next = (!wr_q && legal_q) ? mem_data_out : '0;
        rr_next        = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        busy_next      = 1'b1;
        state_next     = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      rr          <= '0;
      idx         <= '0;
      wr_q        <= 1'b0;
      legal_q     <= 1'b0;
      ack         <= '0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      busy        <= 1'b0;
      mem_address <= '0;
      mem_wr_en   <= 1'b0;
      mem_data_in <= '0;
    end else begin
      state       <= state_next;
      rr          <= rr_next;
      idx         <= idx_next;
      wr_q        <= wr_next;
      legal_q     <= legal_next;
      ack         <= ack_next;
      rsp_err     <= rsp_err_next;
      rsp_rdata   <= rsp_rdata_next;
      busy        <= busy_next;
      mem_address <= mem_address_next;
      mem_wr_en   <= mem_wr_en_next;
      mem_data_in <= mem_data_in_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 2048-byte big-endian memory model attached.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        nrst;
  logic [1:0]  req;
  logic [1:0]  req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  ack;
  logic        rsp_err;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic [15:0] mem_address;
  logic        mem_wr_en;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;

  int checks = 0;
  int passed = 0;

  logic [7:0] mem [0:2047];
  logic       mem_init_done = 1'b0;

  mem_arbiter dut (
    .clock        (clock),
    .nrst         (nrst),
    .req          (req),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .ack          (ack),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .busy         (busy),
    .mem_address  (mem_address),
    .mem_wr_en    (mem_wr_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clock = ~clock;

  // Memory model: preloaded on the first edge, then written big-endian on mem_wr_en.
  always @(posedge clock) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'hFF;
      mem[11'h1C8] <= 8'h00; mem[11'h1C9] <= 8'h10;
      mem[11'h7FE] <= 8'h00; mem[11'h7FF] <= 8'h09;
      mem[11'h048] <= 8'hA5; mem[11'h049] <= 8'h5A;
      mem[11'h600] <= 8'h00; mem[11'h601] <= 8'h00;
      mem_init_done <= 1'b1;
    end else if (mem_wr_en) begin
      mem[mem_address[10:0]]         <= mem_data_in[15:8];
      mem[mem_address[10:0] + 11'd1] <= mem_data_in[7:0];
    end
  end

  assign mem_data_out = {mem[mem_address[10:0]], mem[mem_address[10:0] + 11'd1]};

  task automatic set_req(input int i, input logic wr, input logic [15:0] addr, input logic [15:0] data);
    req_wr[i]           = wr;
    req_addr[i*16 +: 16]  = addr;
    req_wdata[i*16 +: 16] = data;
    req[i]              = 1'b1;
  endtask

  // Issues one request in a fresh IDLE cycle and returns at the negedge of the ack cycle.
  task automatic do_access(input int i, input logic wr, input logic [15:0] addr, input logic [15:0] data);
    @(posedge clock); #1;
    set_req(i, wr, addr, data);
    repeat (3) @(negedge clock);
    req = '0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clock);
    checks++; if ({ack, rsp_err, busy, mem_wr_en} !== 5'b0) $display("[TB] FAIL reset_ctrl: got %b expected 00000", {ack, rsp_err, busy, mem_wr_en}); else passed++;
    checks++; if ({rsp_rdata, mem_address, mem_data_in} !== 48'h0) $display("[TB] FAIL reset_data: got %h expected 0", {rsp_rdata, mem_address, mem_data_in}); else passed++;
    nrst = 1'b1;
    @(negedge clock);
    checks++; if ({ack, busy} !== 3'b000) $display("[TB] FAIL reset_idle: got %b expected 000", {ack, busy}); else passed++;
  endtask

  task automatic test_read();
    @(posedge clock); #1;
    set_req(0, 1'b0, 16'h01C8, 16'h0000);
    @(negedge clock);
    checks++; if ({ack, busy} !== 3'b000) $display("[TB] FAIL read_c0: got %b expected 000", {ack, busy}); else passed++;
    @(negedge clock);
    checks++; if ({mem_wr_en, busy, ack} !== 4'b0100) $display("[TB] FAIL read_c1_ctrl: got %b expected 0100", {mem_wr_en, busy, ack}); else passed++;
    checks++; if (mem_address !== 16'h01C8) $display("[TB] FAIL read_c1_addr: got %h expected 01c8", mem_address); else passed++;
    @(negedge clock);
    checks++; if (ack !== 2'b01) $display("[TB] FAIL read_ack: got %b expected 01", ack); else passed++;
    checks++; if (rsp_rdata !== 16'h0010) $display("[TB] FAIL read_data: got %h expected 0010", rsp_rdata); else passed++;
    checks++; if (rsp_err !== 1'b0) $display("[TB] FAIL read_err: got %b expected 0", rsp_err); else passed++;
    req = '0;
    @(negedge clock);
    checks++; if ({ack, busy} !== 3'b000) $display("[TB] FAIL read_c3: got %b expected 000", {ack, busy}); else passed++;
    checks++; if (rsp_rdata !== 16'h0010) $display("[TB] FAIL read_hold: got %h expected 0010", rsp_rdata); else passed++;
  endtask

  task automatic test_write_read();
    @(posedge clock); #1;
    set_req(1, 1'b1, 16'h0600, 16'hBEEF);
    @(negedge clock);
    checks++; if (mem_wr_en !== 1'b0) $display("[TB] FAIL wr_c0_we: got %b expected 0", mem_wr_en); else passed++;
    @(negedge clock);
    checks++; if (mem_wr_en !== 1'b1) $display("[TB] FAIL wr_c1_we: got %b expected 1", mem_wr_en); else passed++;
    checks++; if ({mem_address, mem_data_in} !== 32'h0600BEEF) $display("[TB] FAIL wr_c1_bus: got %h expected 0600beef", {mem_address, mem_data_in}); else passed++;
    @(negedge clock);
    checks++; if ({mem_wr_en, ack, rsp_err} !== 4'b0100) $display("[TB] FAIL wr_c2_ctrl: got %b expected 0100", {mem_wr_en, ack, rsp_err}); else passed++;
    checks++; if (rsp_rdata !== 16'h0000) $display("[TB] FAIL wr_c2_data: got %h expected 0000", rsp_rdata); else passed++;
    req = '0;
    do_access(1, 1'b0, 16'h0600, 16'h0000);
    checks++; if (ack !== 2'b10) $display("[TB] FAIL rdback_ack: got %b expected 10", ack); else passed++;
    checks++; if (rsp_rdata !== 16'hBEEF) $display("[TB] FAIL rdback_data: got %h expected beef", rsp_rdata); else passed++;
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_ack [0:11];
    logic [11:0] exp_busy;
    exp_ack  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
    exp_busy = 12'b110110110110;
    @(posedge clock); #1;
    set_req(0, 1'b0, 16'h01C8, 16'h0000);
    set_req(1, 1'b0, 16'h0600, 16'h0000);
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      checks++; if (ack !== exp_ack[c]) $display("[TB] FAIL rr_ack_c%0d: got %b expected %b", c, ack, exp_ack[c]); else passed++;
      checks++; if (busy !== exp_busy[c]) $display("[TB] FAIL rr_busy_c%0d: got %b expected %b", c, busy, exp_busy[c]); else passed++;
      if (exp_ack[c] == 2'b01) begin
        checks++; if (rsp_rdata !== 16'h0010) $display("[TB] FAIL rr_data_c%0d: got %h expected 0010", c, rsp_rdata); else passed++;
      end else if (exp_ack[c] == 2'b10) begin
        checks++; if (rsp_rdata !== 16'hBEEF) $display("[TB] FAIL rr_data_c%0d: got %h expected beef", c, rsp_rdata); else passed++;
      end
    end
    req = '0;
  endtask

  task automatic test_illegal_addr();
    @(posedge clock); #1;
    set_req(0, 1'b1, 16'h0049, 16'h1234);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++; if (mem_wr_en !== 1'b0) $display("[TB] FAIL odd_we_c%0d: got %b expected 0", c, mem_wr_en); else passed++;
    end
    checks++; if ({ack, rsp_err} !== 3'b011) $display("[TB] FAIL odd_ack_err: got %b expected 011", {ack, rsp_err}); else passed++;
    checks++; if (rsp_rdata !== 16'h0000) $display("[TB] FAIL odd_data: got %h expected 0000", rsp_rdata); else passed++;
    req = '0;
    checks++; if ({mem[11'h048], mem[11'h049]} !== 16'hA55A) $display("[TB] FAIL odd_mem: got %h expected a55a", {mem[11'h048], mem[11'h049]}); else passed++;
    do_access(1, 1'b0, 16'h0048, 16'h0000);
    checks++; if ({ack, rsp_err, rsp_rdata} !== 19'h4A55A) $display("[TB] FAIL odd_rdback: got %h expected 4a55a", {ack, rsp_err, rsp_rdata}); else passed++;
  endtask

  task automatic test_boundary();
    do_access(0, 1'b0, 16'h07FF, 16'h0000);
    checks++; if ({ack, rsp_err, rsp_rdata} !== 19'h30000) $display("[TB] FAIL bnd_07ff: got %h expected 30000", {ack, rsp_err, rsp_rdata}); else passed++;
    do_access(1, 1'b0, 16'h0800, 16'h0000);
    checks++; if ({ack, rsp_err, rsp_rdata} !== 19'h50000) $display("[TB] FAIL bnd_0800: got %h expected 50000", {ack, rsp_err, rsp_rdata}); else passed++;
    do_access(0, 1'b0, 16'h07FE, 16'h0000);
    checks++; if ({ack, rsp_err, rsp_rdata} !== 19'h20009) $display("[TB] FAIL bnd_07fe: got %h expected 20009", {ack, rsp_err, rsp_rdata}); else passed++;
  endtask

  task automatic test_reset_mid_access();
    @(posedge clock); #1;
    set_req(1, 1'b1, 16'h0600, 16'h5555);
    @(posedge clock); #2;
    checks++; if (mem_wr_en !== 1'b1) $display("[TB] FAIL rst_pre_we: got %b expected 1", mem_wr_en); else passed++;
    nrst = 1'b0;
    #1;
    checks++; if ({ack, rsp_err, busy, mem_wr_en} !== 5'b0) $display("[TB] FAIL rst_async_ctrl: got %b expected 00000", {ack, rsp_err, busy, mem_wr_en}); else passed++;
    checks++; if ({rsp_rdata, mem_address, mem_data_in} !== 48'h0) $display("[TB] FAIL rst_async_data: got %h expected 0", {rsp_rdata, mem_address, mem_data_in}); else passed++;
    req = '0;
    @(posedge clock); #1;
    checks++; if ({mem[11'h600], mem[11'h601]} !== 16'hBEEF) $display("[TB] FAIL rst_no_write: got %h expected beef", {mem[11'h600], mem[11'h601]}); else passed++;
    @(negedge clock);
    nrst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++; if ({ack, busy} !== 3'b000) $display("[TB] FAIL rst_no_ack_c%0d: got %b expected 000", c, {ack, busy}); else passed++;
    end
    @(posedge clock); #1;
    set_req(0, 1'b0, 16'h0600, 16'h0000);
    set_req(1, 1'b0, 16'h0600, 16'h0000);
    repeat (3) @(negedge clock);
    checks++; if (ack !== 2'b01) $display("[TB] FAIL rst_first_ack: got %b expected 01", ack); else passed++;
    checks++; if (rsp_rdata !== 16'hBEEF) $display("[TB] FAIL rst_rdback: got %h expected beef", rsp_rdata); else passed++;
    req = '0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_round_robin();
    test_illegal_addr();
    test_boundary();
    test_reset_mid_access();
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
